// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int unsigned QUEUE_DEPTH       = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between the memory response and decode.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

    fetch_entry_t     r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_head  = r_mem[r_rd];

    // A push into an empty queue that is popped the same cycle is consumed by
    // the bypass path in the parent and never stored.
    assign w_do_push = i_push && !(i_pop && o_empty);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PTR_W'(1);
            if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: request issue, in-order response tracking, redirect drop.
// Optional FETCH_PERF_CNT_EN adds a popped-instruction counter port.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        if_valid,
    output logic        id_flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt
`endif
);

    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_pc_last;
    logic [1:0]   r_outst;
    logic [1:0]   r_drop;

    logic [31:0]  w_redirect_pc;
    logic [1:0]   w_occ;
    logic [1:0]   w_live;
    logic         w_hs;
    logic         w_rsp_live;
    logic         w_rsp_drop;
    logic         w_push;
    logic         w_pop;
    logic         w_if_valid;
    logic         w_q_full;
    logic         w_q_empty;
    fetch_entry_t w_rsp_entry;
    fetch_entry_t w_q_head;
    fetch_entry_t w_head;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_occ         = {w_q_full, !w_q_full && !w_q_empty};

    assign imem_req_valid = rst && !redirect_valid && (({1'b0, r_outst} + {1'b0, w_occ}) < 3'd2);
    assign imem_req_addr  = r_fetch_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. stragglers from before reset) are ignored.
    assign w_rsp_live = imem_rsp_valid && (r_outst != 2'd0);
    assign w_rsp_drop = w_rsp_live && (r_drop != 2'd0);
    assign w_push     = w_rsp_live && (r_drop == 2'd0) && !redirect_valid;

    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one's pc is recovered from the counters instead of being stored.
    assign w_live            = r_outst - r_drop;
    assign w_rsp_entry.pc    = r_fetch_pc - {28'd0, w_live, 2'b00};
    assign w_rsp_entry.instr = imem_rsp_data;

    assign w_if_valid = !redirect_valid && (!w_q_empty || w_push);
    assign w_head     = w_q_empty ? w_rsp_entry : w_q_head;
    assign w_pop      = w_if_valid && !id_stall;

    assign if_valid        = w_if_valid;
    assign id_flush        = !w_if_valid;
    assign instruction_out = w_if_valid ? w_head.instr : NOP_INSTR;
    assign pc_out          = w_if_valid ? w_head.pc : r_pc_last;

    fetch_queue u_queue (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .i_data  (w_rsp_entry),
        .o_head  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_pc_last  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_drop     <= r_outst - {1'b0, w_rsp_live};
            end else begin
                if (w_hs)       r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp_drop) r_drop     <= r_drop - 2'd1;
            end
            case ({w_hs, w_rsp_live})
                2'b10:   r_outst <= r_outst + 2'd1;
                2'b01:   r_outst <= r_outst - 2'd1;
                default: r_outst <= r_outst;
            endcase
            if (w_if_valid) r_pc_last <= w_head.pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_perf_cnt <= '0;
        else if (w_pop) r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_fetch_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle-latency memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        id_flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
`endif

    logic [31:0] mem_q[$];
    bit          rsp_hold;
    int unsigned pass_cnt;
    int unsigned total_cnt;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .if_valid        (if_valid),
        .id_flush        (id_flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    // Samples the handshake, advances one edge, then presents the next response.
    task automatic tick();
        bit          hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) mem_q.push_back(a);
        if (!rsp_hold && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
        imem_req_ready = 1'b1;
        rsp_hold       = 1'b0;
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0h expected 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %0h expected 0", if_valid); else pass_cnt++;
        total_cnt++; if (id_flush !== 1'b1) $display("FAIL reset_id_flush: got %0h expected 1", id_flush); else pass_cnt++;
        total_cnt++; if (instruction_out !== 32'h0000_0013) $display("FAIL reset_instr: got %h expected 00000013", instruction_out); else pass_cnt++;
        total_cnt++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h expected 00000000", pc_out); else pass_cnt++;
        total_cnt++; if (imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) $display("FAIL stream_req c%0d: got v=%0h a=%h expected v=1 a=%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (if_valid !== 1'b0) $display("FAIL stream_first_if_valid: got %0h expected 0", if_valid); else pass_cnt++;
            end else begin
                exp_pc = 32'(4 * (i - 1));
                total_cnt++; if (if_valid !== 1'b1 || pc_out !== exp_pc || instruction_out !== instr_of(exp_pc)) $display("FAIL stream_out c%0d: got v=%0h pc=%h i=%h expected v=1 pc=%h i=%h", i, if_valid, pc_out, instruction_out, exp_pc, instr_of(exp_pc)); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        int unsigned pops;
        apply_reset();
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i >= 1) begin
                total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h0) $display("FAIL stall_hold c%0d: got v=%0h pc=%h expected v=1 pc=00000000", i, if_valid, pc_out); else pass_cnt++;
            end
            if (i >= 2) begin
                total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid c%0d: got %0h expected 0", i, imem_req_valid); else pass_cnt++;
            end
            tick();
        end
        id_stall = 1'b0;
        exp_pc   = 32'h0;
        pops     = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (if_valid) begin
                total_cnt++; if (pc_out !== exp_pc || instruction_out !== instr_of(exp_pc)) $display("FAIL stall_release_seq: got pc=%h i=%h expected pc=%h i=%h", pc_out, instruction_out, exp_pc, instr_of(exp_pc)); else pass_cnt++;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            tick();
        end
        total_cnt++; if (pops != 12) $display("FAIL stall_release_pops: got %0d expected 12", pops); else pass_cnt++;
    endtask

    task automatic test_redirect();
        apply_reset();
        rsp_hold = 1'b1;
        #1; tick();
        #1; tick();
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL redir_two_outstanding_req: got %0h expected 0", imem_req_valid); else pass_cnt++;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        rsp_hold       = 1'b0;
        #1;
        total_cnt++; if (id_flush !== 1'b1 || if_valid !== 1'b0) $display("FAIL redir_cycle_flush: got flush=%0h v=%0h expected flush=1 v=0", id_flush, if_valid); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL redir_cycle_req: got %0h expected 0", imem_req_valid); else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        #1;
        total_cnt++; if (imem_req_addr !== 32'h0000_0100) $display("FAIL redir_aligned_addr: got %h expected 00000100", imem_req_addr); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0 || pc_out !== 32'h0) $display("FAIL redir_drop1: got v=%0h pc=%h expected v=0 pc=00000000", if_valid, pc_out); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1) $display("FAIL redir_drop2: got v=%0h req=%0h expected v=0 req=1", if_valid, imem_req_valid); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h100 || instruction_out !== instr_of(32'h100)) $display("FAIL redir_target: got v=%0h pc=%h i=%h expected v=1 pc=00000100 i=%h", if_valid, pc_out, instruction_out, instr_of(32'h100)); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h104) $display("FAIL redir_next: got v=%0h pc=%h expected v=1 pc=00000104", if_valid, pc_out); else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL wrap_redir_req: got %0h expected 0", imem_req_valid); else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        #1;
        total_cnt++; if (imem_req_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_addr0: got %h expected fffffff8", imem_req_addr); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (imem_req_addr !== 32'hFFFF_FFFC || pc_out !== 32'hFFFF_FFF8) $display("FAIL wrap_addr1: got a=%h pc=%h expected a=fffffffc pc=fffffff8", imem_req_addr, pc_out); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (imem_req_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_addr2: got a=%h pc=%h expected a=00000000 pc=fffffffc", imem_req_addr, pc_out); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h0 || instruction_out !== instr_of(32'h0)) $display("FAIL wrap_out0: got v=%0h pc=%h i=%h expected v=1 pc=00000000 i=%h", if_valid, pc_out, instruction_out, instr_of(32'h0)); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        #1; tick();
        #1; tick();
        #1; tick();
        #1;
        total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h8) $display("FAIL midrst_pre: got v=%0h pc=%h expected v=1 pc=00000008", if_valid, pc_out); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (if_valid !== 1'b0 || id_flush !== 1'b1) $display("FAIL midrst_valid: got v=%0h flush=%0h expected v=0 flush=1", if_valid, id_flush); else pass_cnt++;
        total_cnt++; if (instruction_out !== 32'h13 || pc_out !== 32'h0) $display("FAIL midrst_out: got i=%h pc=%h expected i=00000013 pc=00000000", instruction_out, pc_out); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL midrst_req: got %0h expected 0", imem_req_valid); else pass_cnt++;
        @(posedge clk);
        #1;
        mem_q.delete();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000;
        rst            = 1'b1;
        #1;
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL midrst_late_rsp: got v=%0h expected 0", if_valid); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL midrst_restart: got v=%0h a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (if_valid !== 1'b1 || pc_out !== 32'h0 || instruction_out !== instr_of(32'h0)) $display("FAIL midrst_first: got v=%0h pc=%h i=%h expected v=1 pc=00000000 i=%h", if_valid, pc_out, instruction_out, instr_of(32'h0)); else pass_cnt++;
        tick();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            #1; tick();
        end
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        total_cnt++; if (perf_fetch_cnt !== 32'd10) $display("FAIL perf_ten_pops: got %0d expected 10", perf_fetch_cnt); else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        #1; tick();
        #1;
        total_cnt++; if (perf_fetch_cnt !== 32'd10) $display("FAIL perf_after_drop: got %0d expected 10", perf_fetch_cnt); else pass_cnt++;
        id_stall = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rsp_hold  = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
